md_unit: RTL



---
 rtl/md_unit_pkg.sv | 31 +++
 rtl/md_unit_counter.sv | 54 +++++
 rtl/md_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared MD-unit definitions: opcode encodings, sequencer states and opcode
// class helpers used by md_unit, the D-stage decoder and the hazard unit.
package md_defs;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the opcodes that launch a multi-cycle mult/div.
  function automatic logic md_is_muldiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_counter.sv
// Busy-cycle sequencer: loads a cycle count, decrements to zero and pulses
// done on the edge where the count goes 1->0 (the HI/LO commit edge).
module md_counter
  import md_defs::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load in IDLE, count down in BUSY, flag the final edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (load && (load_val != '0)) begin
          cnt_d   = load_val;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    busy = (state_q == MD_BUSY);
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at launch into pending regs and committed to HI/LO
// only when the busy countdown finishes.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] MDOp_E,
  input  logic [31:0]        A_E,
  input  logic [31:0]        B_E,
  output logic               E_Start,
  output logic               E_Busy,
  output logic [31:0]        MDOut_E
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_dz_q, pend_dz_d;
  logic        done;
  logic [3:0]  load_val;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, sdiv, udiv;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [63:0] prod_u, prod_mag, prod_s, result;
  logic        div_zero;

  md_counter #(.CNT_W(4)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (E_Start),
    .load_val (load_val),
    .busy     (E_Busy),
    .done     (done)
  );

  // Arithmetic: signed ops use magnitudes and fix up signs afterwards, so
  // 0x80000000 / -1 wraps to 0x80000000 rem 0 without a special case.
  // Zero divisors are replaced by 1; such results are never committed.
  always_comb begin
    a_neg    = A_E[31];
    b_neg    = B_E[31];
    a_mag    = a_neg ? (~A_E + 32'd1) : A_E;
    b_mag    = b_neg ? (~B_E + 32'd1) : B_E;
    prod_u   = {32'd0, A_E} * {32'd0, B_E};
    prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
    prod_s   = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;
    sdiv     = (b_mag == '0) ? 32'd1 : b_mag;
    udiv     = (B_E == '0) ? 32'd1 : B_E;
    q_mag    = a_mag / sdiv;
    r_mag    = a_mag % sdiv;
    q_s      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_s      = a_neg ? (~r_mag + 32'd1) : r_mag;
    q_u      = A_E / udiv;
    r_u      = A_E % udiv;
    div_zero = (B_E == '0);
    unique case (MDOp_E)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {r_s, q_s};
      MD_DIVU:  result = {r_u, q_u};
      default:  result = '0;
    endcase
  end

  // Launch, pending capture, HI/LO update and read mux.
  always_comb begin
    E_Start   = md_is_muldiv(MDOp_E) && !E_Busy;
    load_val  = md_is_mult(MDOp_E) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    if (E_Start) begin
      pend_d    = result;
      pend_dz_d = div_zero && !md_is_mult(MDOp_E);
    end
    hi_d = hi_q;
    lo_d = lo_q;
    if (done) begin
      if (!pend_dz_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (!E_Busy) begin
      if (MDOp_E == MD_MTHI) hi_d = A_E;
      if (MDOp_E == MD_MTLO) lo_d = A_E;
    end
    if (MDOp_E == MD_MFHI)      MDOut_E = hi_q;
    else if (MDOp_E == MD_MFLO) MDOut_E = lo_q;
    else                        MDOut_E = '0;
  end

  // Architectural and pending registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
    end
  end

endmodule
